pbutton_bounce_gen: RTL and testbench
=====================================

# pbutton_bounce_gen

Push-button bounce generator for the debouncer test designs. It turns a clean press/release command into a PB waveform with configurable contact bounce: a number of glitches, a per-glitch interval with pseudo-random jitter, and a settle time. It sits in the test top level in place of a physical key, driving the debouncer's PB input so the debouncer can be exercised and timed on hardware and in simulation.

## Interface
Parameters:
- PB_ACTIVE_STATE_HIGH, 0: electrical level of an active (pushed) PB. 0 means PB is low when pushed; 1 means PB is high when pushed.
- LFSR_SEED, 16'hACE1: jitter LFSR reset value. Must be nonzero.

Ports:
- CLOCK_50, in, 1: the single clock (50 MHz).
- RESET, in, 1: asynchronous, active-high reset.
- cmd_press, in, 1: single-cycle request to push the button.
- cmd_release, in, 1: single-cycle request to release the button.
- nb_bounce, in, 8: number of glitch pairs (N).
- bounce_period, in, 32: base segment length in cycles (P).
- jitter_mask, in, 16: mask ANDed with the LFSR to form per-segment extra cycles.
- settle_cycles, in, 32: cycles from the last edge to `done` (S).
- PB, out, 1: generated electrical button signal.
- pb_level, out, 1: logical target state; 1 = pushed.
- busy, out, 1: a sequence is in progress.
- done, out, 1: one-cycle pulse when a sequence completes.
- rejected, out, 1: one-cycle pulse when a command is ignored.

## Operation
- States:
  - IDLE: waits for a command.
  - BOUNCE: generates the glitch edges.
  - SETTLE: holds the final level while counting S cycles.
- Logical level `lvl`. PB = lvl when PB_ACTIVE_STATE_HIGH = 1, otherwise PB = ~lvl. PB is registered.
- Accept rule, in IDLE only:
  - cmd_press is accepted when pb_level = 0.
  - cmd_release is accepted when pb_level = 1.
- Reject rule: `rejected` pulses when any of the following occurs, and state is unchanged:
  - a command arrives while busy;
  - a command targets the current pb_level;
  - cmd_press and cmd_release are asserted in the same cycle.
- On accept:
  - Latch N, P, jitter_mask and S.
  - Set pb_level and lvl to the target.
  - Enter BOUNCE with edge counter = 2N.
- BOUNCE:
  - Each segment holds lvl for L = P + (lfsr & jitter_mask) cycles, then toggles lvl and decrements the edge counter.
  - When the counter reaches 0, enter SETTLE.
  - Because 2N toggles follow the initial edge, lvl always ends equal to pb_level.
  - N = 0 means a single clean edge, then SETTLE directly.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances once at the start of each segment.
  - Free of lock-up as long as the seed is nonzero.
- Arithmetic:
  - L is computed in 33 bits and saturates to 32'hFFFFFFFF.
  - P = 0 or L = 0 is treated as 1.
  - S = 0 is treated as 1.
- SETTLE: counts S cycles, pulses `done`, returns to IDLE.
- Reset (async, any state):
  - State IDLE, lvl = 0, pb_level = 0, PB = inactive level (1 when PB_ACTIVE_STATE_HIGH = 0).
  - busy = 0, done = 0, rejected = 0, lfsr = LFSR_SEED, counters = 0.
  - A reset mid-sequence aborts it; no `done` is issued.

## Timing
- Command sampled at clock edge t:
  - the first PB edge is visible after edge t (cycle t+1);
  - `busy` rises in the same cycle.
- With jitter_mask = 0, PB edges fall at t+1+k·P for k = 0…2N.
- `done` is high for exactly the one cycle t+1+2N·P+S.
- `busy` is high from t+1 through the `done` cycle inclusive, and is low the following cycle.
- The earliest next accepted command is sampled the cycle after `done`.
- `rejected` is high the cycle after the offending command's sampling edge, and is a single cycle.
- Config inputs only matter on the accept edge; changes during a sequence have no effect.

## Test plan
- Reset, PB_ACTIVE_STATE_HIGH = 0 -> PB = 1, busy/done/rejected/pb_level = 0.
- cmd_press, N = 3, P = 10, mask = 0, S = 20, command at cycle 0 -> PB edges at cycles 1, 11, 21, 31, 41, 51, 61 (7 edges). Final PB = 0, done at cycle 81, busy for cycles 1–81.
- cmd_press, N = 0, P = 5, S = 1 -> one clean edge at cycle 1, done at cycle 2. Then cmd_press again -> rejected pulse, PB unchanged.
- cmd_release during BOUNCE, and cmd_press + cmd_release together in IDLE -> each gives one rejected pulse; the sequence timing is unaffected.
- mask = 16'h000F, P = 100 -> every segment length is in [100, 115]. The sequence repeats exactly for the same seed after reset.
- Assert RESET mid-BOUNCE -> PB returns to 1 immediately, busy = 0, no done. Closed loop with the debouncer (nb_debounce_cycle = 50, P = 10, N = 4) -> exactly one PB_state_pushed per accepted press.

Source files
------------

// File: rtl/pbutton_bounce_gen.sv
// -----------------------------------------------------------------------------
// pbutton_bounce_gen
//
// Push-button bounce generator. Stands in for a physical key in the debouncer
// test tops: a clean press/release command becomes a PB waveform with a burst
// of contact glitches, per-glitch jitter taken from an LFSR, and a settle time
// before completion is reported.
//
// Parameters
//   PB_ACTIVE_STATE_HIGH : 0 -> PB is low when pushed, 1 -> PB is high when pushed
//   LFSR_SEED            : jitter LFSR reset value (must be nonzero)
//
// Ports
//   CLOCK_50      in   1  single clock
//   RESET         in   1  asynchronous active-high reset
//   cmd_press     in   1  one-cycle push request
//   cmd_release   in   1  one-cycle release request
//   nb_bounce     in   8  number of glitch pairs N
//   bounce_period in  32  base segment length P (cycles)
//   jitter_mask   in  16  ANDed with the LFSR to give extra cycles per segment
//   settle_cycles in  32  cycles from last edge to done (S)
//   PB            out  1  generated electrical button level (registered)
//   pb_level      out  1  logical target state, 1 = pushed
//   busy          out  1  sequence in progress (through the done cycle)
//   done          out  1  one-cycle completion pulse
//   rejected      out  1  one-cycle pulse for an ignored command
// -----------------------------------------------------------------------------
module pbutton_bounce_gen #(
    parameter logic        PB_ACTIVE_STATE_HIGH = 1'b0,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        cmd_press,
    input  logic        cmd_release,
    input  logic [7:0]  nb_bounce,
    input  logic [31:0] bounce_period,
    input  logic [15:0] jitter_mask,
    input  logic [31:0] settle_cycles,
    output logic        PB,
    output logic        pb_level,
    output logic        busy,
    output logic        done,
    output logic        rejected
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t      state_reg,      state_next;
    logic        lvl_reg,        lvl_next;
    logic        pb_level_reg,   pb_level_next;
    logic        pb_reg;
    logic        busy_reg,       busy_next;
    logic        done_reg,       done_next;
    logic        rejected_reg,   rejected_next;
    logic [8:0]  edge_cnt_reg,   edge_cnt_next;
    logic [31:0] seg_cnt_reg,    seg_cnt_next;
    logic [31:0] settle_cnt_reg, settle_cnt_next;
    logic [15:0] lfsr_reg,       lfsr_next;
    logic [31:0] period_reg,     period_next;
    logic [15:0] mask_reg,       mask_next;
    logic [31:0] settle_reg,     settle_next;

    // ------------------------------------------------------------------
    // Segment length datapath.
    // On the accept edge the first segment is sized from the live inputs;
    // afterwards the latched copies are used so that config changes during
    // a sequence have no effect.
    // ------------------------------------------------------------------
    logic [15:0] lfsr_adv;
    logic [31:0] seg_period_src;
    logic [15:0] seg_mask_src;
    logic [15:0] jitter;
    logic [31:0] period_eff;
    logic [32:0] seg_sum;
    logic [31:0] seg_len;
    logic [31:0] seg_len_m1;
    logic [31:0] settle_src;
    logic [31:0] settle_m1;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    assign lfsr_adv = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                       lfsr_reg[15:1]};

    assign seg_period_src = (state_reg == ST_IDLE) ? bounce_period : period_reg;
    assign seg_mask_src   = (state_reg == ST_IDLE) ? jitter_mask   : mask_reg;

    // The segment that is about to start uses the freshly advanced LFSR value.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_jitter
            assign jitter[gi] = lfsr_adv[gi] & seg_mask_src[gi];
        end
    endgenerate

    // A zero period would mean a zero-length segment; treat it as one cycle.
    assign period_eff = (seg_period_src == 32'd0) ? 32'd1 : seg_period_src;
    assign seg_sum    = {1'b0, period_eff} + {17'd0, jitter};
    // Saturate the 33-bit sum; period_eff >= 1 so seg_len is never zero.
    assign seg_len    = seg_sum[32] ? 32'hFFFF_FFFF : seg_sum[31:0];
    // The segment counter runs from L-1 down to 0, so the toggle lands
    // exactly L cycles after the previous edge.
    assign seg_len_m1 = seg_len - 32'd1;

    assign settle_src = (state_reg == ST_IDLE) ? settle_cycles : settle_reg;
    assign settle_m1  = (settle_src == 32'd0) ? 32'd0 : (settle_src - 32'd1);

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic cmd_any;
    logic cmd_both;
    logic cmd_target;

    assign cmd_any    = cmd_press | cmd_release;
    assign cmd_both   = cmd_press & cmd_release;
    assign cmd_target = cmd_press;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        lvl_next        = lvl_reg;
        pb_level_next   = pb_level_reg;
        done_next       = 1'b0;
        rejected_next   = 1'b0;
        edge_cnt_next   = edge_cnt_reg;
        seg_cnt_next    = seg_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        lfsr_next       = lfsr_reg;
        period_next     = period_reg;
        mask_next       = mask_reg;
        settle_next     = settle_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_any) begin
                    // busy_reg is still high in the done cycle, which keeps
                    // the earliest accept one cycle after done.
                    if (cmd_both || busy_reg || (cmd_target == pb_level_reg)) begin
                        rejected_next = 1'b1;
                    end else begin
                        pb_level_next = cmd_target;
                        lvl_next      = cmd_target;
                        period_next   = bounce_period;
                        mask_next     = jitter_mask;
                        settle_next   = settle_cycles;
                        if (nb_bounce == 8'd0) begin
                            // Clean single edge: go straight to settling.
                            edge_cnt_next   = 9'd0;
                            settle_cnt_next = settle_m1;
                            state_next      = ST_SETTLE;
                        end else begin
                            edge_cnt_next = {nb_bounce, 1'b0};
                            lfsr_next     = lfsr_adv;
                            seg_cnt_next  = seg_len_m1;
                            state_next    = ST_BOUNCE;
                        end
                    end
                end
            end

            ST_BOUNCE: begin
                if (cmd_any) begin
                    rejected_next = 1'b1;
                end
                if (seg_cnt_reg == 32'd0) begin
                    lvl_next      = ~lvl_reg;
                    edge_cnt_next = edge_cnt_reg - 9'd1;
                    if (edge_cnt_reg == 9'd1) begin
                        // Even number of toggles: lvl now equals pb_level.
                        settle_cnt_next = settle_m1;
                        state_next      = ST_SETTLE;
                    end else begin
                        lfsr_next    = lfsr_adv;
                        seg_cnt_next = seg_len_m1;
                    end
                end else begin
                    seg_cnt_next = seg_cnt_reg - 32'd1;
                end
            end

            ST_SETTLE: begin
                if (cmd_any) begin
                    rejected_next = 1'b1;
                end
                if (settle_cnt_reg == 32'd0) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 32'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // busy covers the done cycle as well.
        busy_next = (state_next != ST_IDLE) || done_next;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            lvl_reg        <= 1'b0;
            pb_level_reg   <= 1'b0;
            pb_reg         <= ~PB_ACTIVE_STATE_HIGH;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rejected_reg   <= 1'b0;
            edge_cnt_reg   <= 9'd0;
            seg_cnt_reg    <= 32'd0;
            settle_cnt_reg <= 32'd0;
            lfsr_reg       <= LFSR_SEED;
            period_reg     <= 32'd0;
            mask_reg       <= 16'd0;
            settle_reg     <= 32'd0;
        end else begin
            state_reg      <= state_next;
            lvl_reg        <= lvl_next;
            pb_level_reg   <= pb_level_next;
            // PB follows the next logical level so the first edge appears in
            // the same cycle that busy rises.
            pb_reg         <= PB_ACTIVE_STATE_HIGH ? lvl_next : ~lvl_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            rejected_reg   <= rejected_next;
            edge_cnt_reg   <= edge_cnt_next;
            seg_cnt_reg    <= seg_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            lfsr_reg       <= lfsr_next;
            period_reg     <= period_next;
            mask_reg       <= mask_next;
            settle_reg     <= settle_next;
        end
    end

    assign PB       = pb_reg;
    assign pb_level = pb_level_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rejected = rejected_reg;

endmodule

// File: tb/tb_pbutton_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_pbutton_bounce_gen
//
// Scoreboard bench. Each command is evaluated by a reference model that
// works in absolute cycle numbers and pushes the expected PB edges, done
// pulse and rejected pulse into queues; a monitor on the falling clock edge
// pops and compares whatever the DUT presents, and also checks busy and
// pb_level every cycle against the model's busy window and level.
// -----------------------------------------------------------------------------
module tb_pbutton_bounce_gen;

    localparam logic        ACTIVE_HIGH = 1'b0;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic        CLOCK_50;
    logic        RESET;
    logic        cmd_press;
    logic        cmd_release;
    logic [7:0]  nb_bounce;
    logic [31:0] bounce_period;
    logic [15:0] jitter_mask;
    logic [31:0] settle_cycles;
    logic        PB;
    logic        pb_level;
    logic        busy;
    logic        done;
    logic        rejected;

    pbutton_bounce_gen #(
        .PB_ACTIVE_STATE_HIGH (ACTIVE_HIGH),
        .LFSR_SEED            (SEED)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .cmd_press     (cmd_press),
        .cmd_release   (cmd_release),
        .nb_bounce     (nb_bounce),
        .bounce_period (bounce_period),
        .jitter_mask   (jitter_mask),
        .settle_cycles (settle_cycles),
        .PB            (PB),
        .pb_level      (pb_level),
        .busy          (busy),
        .done          (done),
        .rejected      (rejected)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Current cycle number; cycle c runs between the edge that starts it and
    // the edge that ends it.
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   at;
        logic val;
    } edge_ev_t;

    edge_ev_t edge_q[$];
    int       done_q[$];
    int       rej_q[$];

    // Reference model state
    logic [15:0] m_lfsr;
    logic        m_level;
    logic        m_old_level;
    int          m_lvl_change;
    int          m_busy_from;
    int          m_busy_until;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int at);
        checks++;
        errors++;
        $display("FAIL %s: expected/observed event mismatch at cycle %0d (now %0d)", name, at, cyc);
    endtask

    function automatic logic pb_of(input logic v);
        return ACTIVE_HIGH ? v : ~v;
    endfunction

    // One LFSR step for x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic void model_reset();
        m_lfsr       = SEED;
        m_level      = 1'b0;
        m_old_level  = 1'b0;
        m_lvl_change = 0;
        m_busy_from  = 0;
        m_busy_until = -1;
        edge_q.delete();
        done_q.delete();
        rej_q.delete();
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic prev_pb = 1'b1;

    always @(negedge CLOCK_50) begin
        if (RESET !== 1'b0) begin
            prev_pb = PB;
        end else begin
            while (edge_q.size() > 0 && edge_q[0].at < cyc) begin
                flag("pb_edge_missing", edge_q[0].at);
                void'(edge_q.pop_front());
            end
            if (PB !== prev_pb) begin
                if (edge_q.size() == 0) begin
                    flag("pb_edge_unexpected", cyc);
                end else begin
                    edge_ev_t e;
                    e = edge_q.pop_front();
                    check("pb_edge_cycle", cyc, e.at);
                    check("pb_edge_value", PB, e.val);
                end
            end
            prev_pb = PB;

            while (done_q.size() > 0 && done_q[0] < cyc) begin
                flag("done_missing", done_q[0]);
                void'(done_q.pop_front());
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) flag("done_unexpected", cyc);
                else check("done_cycle", cyc, done_q.pop_front());
            end

            while (rej_q.size() > 0 && rej_q[0] < cyc) begin
                flag("rejected_missing", rej_q[0]);
                void'(rej_q.pop_front());
            end
            if (rejected === 1'b1) begin
                if (rej_q.size() == 0) flag("rejected_unexpected", cyc);
                else check("rejected_cycle", cyc, rej_q.pop_front());
            end

            check("busy", busy, (cyc >= m_busy_from && cyc <= m_busy_until) ? 1 : 0);
            check("pb_level", pb_level, (cyc >= m_lvl_change) ? m_level : m_old_level);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_cmd(input bit p, input bit r, input int n, input int per,
                          input int msk, input int s);
        int       c;
        bit       tgt;
        bit       busy_now;
        int       e;
        logic     v;
        int       len;
        @(posedge CLOCK_50);
        #1;
        cmd_press     = p;
        cmd_release   = r;
        nb_bounce     = n[7:0];
        bounce_period = per;
        jitter_mask   = msk[15:0];
        settle_cycles = s;
        c        = cyc;
        tgt      = p;
        busy_now = (c >= m_busy_from && c <= m_busy_until);
        if ((p && r) || busy_now || (tgt == m_level)) begin
            rej_q.push_back(c + 1);
            $display("cmd cyc=%0d press=%0d release=%0d -> ignored", c, p, r);
        end else begin
            m_old_level  = m_level;
            m_level      = tgt;
            m_lvl_change = c + 1;
            e = c + 1;
            v = tgt;
            edge_q.push_back('{e, pb_of(v)});
            for (int k = 0; k < 2 * n; k++) begin
                m_lfsr = lfsr_step(m_lfsr);
                len = ((per == 0) ? 1 : per) + int'(m_lfsr & msk[15:0]);
                e   = e + len;
                v   = ~v;
                edge_q.push_back('{e, pb_of(v)});
            end
            e = e + ((s == 0) ? 1 : s);
            done_q.push_back(e);
            m_busy_from  = c + 1;
            m_busy_until = e;
            $display("cmd cyc=%0d press=%0d release=%0d N=%0d P=%0d mask=%h S=%0d -> accepted, done at %0d",
                     c, p, r, n, per, msk[15:0], s, e);
        end
        @(posedge CLOCK_50);
        #1;
        cmd_press     = 1'b0;
        cmd_release   = 1'b0;
        // Scramble config: it must be ignored outside the accept edge.
        nb_bounce     = 8'($urandom);
        bounce_period = $urandom;
        jitter_mask   = 16'($urandom);
        settle_cycles = $urandom;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 5000; i++) begin
            if (edge_q.size() == 0 && done_q.size() == 0 && rej_q.size() == 0) break;
            @(posedge CLOCK_50);
        end
        if (i == 5000) begin
            flag("drain_timeout", cyc);
            edge_q.delete();
            done_q.delete();
            rej_q.delete();
        end
        @(posedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50);
        #3;
        RESET = 1'b1;
        model_reset();
        #1;
        check("reset_pb", PB, pb_of(1'b0));
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rejected", rejected, 0);
        check("reset_pb_level", pb_level, 0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        $display("reset cyc=%0d", cyc);
    endtask

    initial begin
        int sel, n, per, msk, s, gap;
        bit p, r;
        RESET         = 1'b0;
        cmd_press     = 1'b0;
        cmd_release   = 1'b0;
        nb_bounce     = 8'd0;
        bounce_period = 32'd0;
        jitter_mask   = 16'd0;
        settle_cycles = 32'd0;
        model_reset();
        #2;
        do_reset();

        // Reference sequence: 7 edges, done 81 cycles after the command.
        do_cmd(1, 0, 3, 10, 0, 20);
        drain();
        // Release, then clean single edge, then a same-level press.
        do_cmd(0, 1, 2, 4, 0, 3);
        drain();
        do_cmd(1, 0, 0, 5, 0, 1);
        drain();
        do_cmd(1, 0, 0, 5, 0, 1);
        drain();
        // Command during BOUNCE, then both commands together in IDLE.
        do_cmd(0, 1, 3, 8, 0, 4);
        repeat (4) @(posedge CLOCK_50);
        do_cmd(0, 1, 1, 3, 0, 2);
        drain();
        do_cmd(1, 1, 1, 3, 0, 2);
        drain();
        // Zero period / zero settle boundary.
        do_cmd(1, 0, 2, 0, 0, 0);
        drain();
        // Jittered segments; the seed restarts on each reset.
        do_reset();
        do_cmd(1, 0, 3, 100, 16'h000F, 3);
        drain();
        do_reset();
        do_cmd(1, 0, 3, 100, 16'h000F, 3);
        drain();
        // Reset in the middle of BOUNCE: no done may follow.
        do_cmd(0, 1, 3, 10, 0, 5);
        repeat (15) @(posedge CLOCK_50);
        do_reset();
        repeat (60) @(posedge CLOCK_50);

        // Randomized commands, many of them colliding with busy sequences.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    begin p = 1; r = 0; end
                2, 3:    begin p = 0; r = 1; end
                4:       begin p = 1; r = 1; end
                default: begin p = ~m_level; r = m_level; end
            endcase
            n   = $urandom_range(0, 4);
            per = $urandom_range(1, 12);
            case ($urandom_range(0, 3))
                0:       msk = 0;
                1:       msk = 3;
                2:       msk = 7;
                default: msk = 15;
            endcase
            s   = $urandom_range(0, 15);
            do_cmd(p, r, n, per, msk, s);
            gap = $urandom_range(0, 60);
            repeat (gap) @(posedge CLOCK_50);
            if (it % 6 == 5) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
